// File: rtl/axil_arbiter2.sv
// -----------------------------------------------------------------------------
// axil_arbiter2
//
// Round-robin arbiter that shares one AXI-Lite slave port between two AXI-Lite
// masters. Master 0 is the Wishbone-to-AXI-Lite bridge. Master 1 is the
// DMA/configuration engine. One complete transaction is granted at a time:
// either a write (AW + W) or a read (AR + R).
//
// Handshake semantics (all channels): a beat transfers on a rising clock edge
// where valid and ready are both high. A valid, once raised, is held with
// stable payload until that edge.
//
// Ports
//   wb_clk_i, wb_rst_i       clock, synchronous active-high reset
//   m0_* / m1_*              master-side AW, W, AR and R channels
//   aw*, w*, ar*, r*         slave-side channels
//   gnt                      currently or most recently granted master
//   dbg_st                   FSM state (0 = IDLE, 1 = WR, 2 = RD)
//   dbg_last                 last fully served master
// -----------------------------------------------------------------------------
module axil_arbiter2 #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    // master 0
    input  logic                   m0_awvalid,
    output logic                   m0_awready,
    input  logic [pADDR_WIDTH-1:0] m0_awaddr,
    input  logic                   m0_wvalid,
    output logic                   m0_wready,
    input  logic [pDATA_WIDTH-1:0] m0_wdata,
    input  logic                   m0_arvalid,
    output logic                   m0_arready,
    input  logic [pADDR_WIDTH-1:0] m0_araddr,
    output logic                   m0_rvalid,
    input  logic                   m0_rready,
    output logic [pDATA_WIDTH-1:0] m0_rdata,
    // master 1
    input  logic                   m1_awvalid,
    output logic                   m1_awready,
    input  logic [pADDR_WIDTH-1:0] m1_awaddr,
    input  logic                   m1_wvalid,
    output logic                   m1_wready,
    input  logic [pDATA_WIDTH-1:0] m1_wdata,
    input  logic                   m1_arvalid,
    output logic                   m1_arready,
    input  logic [pADDR_WIDTH-1:0] m1_araddr,
    output logic                   m1_rvalid,
    input  logic                   m1_rready,
    output logic [pDATA_WIDTH-1:0] m1_rdata,
    // slave
    output logic                   awvalid,
    input  logic                   awready,
    output logic [pADDR_WIDTH-1:0] awaddr,
    output logic                   wvalid,
    input  logic                   wready,
    output logic [pDATA_WIDTH-1:0] wdata,
    output logic                   arvalid,
    input  logic                   arready,
    output logic [pADDR_WIDTH-1:0] araddr,
    input  logic                   rvalid,
    output logic                   rready,
    input  logic [pDATA_WIDTH-1:0] rdata,
    // status
    output logic                   gnt,
    output logic [1:0]             dbg_st,
    output logic                   dbg_last
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } st_t;

    st_t  st, st_nxt;
    logic gnt_nxt;
    logic last, last_nxt;
    logic aw_done, aw_done_nxt;
    logic w_done, w_done_nxt;
    logic ar_done, ar_done_nxt;

    // request terms
    logic wreq0, wreq1, req0, req1, pick;
    assign wreq0 = m0_awvalid | m0_wvalid;
    assign wreq1 = m1_awvalid | m1_wvalid;
    assign req0  = wreq0 | m0_arvalid;
    assign req1  = wreq1 | m1_arvalid;
    // on a tie the master that was not served last wins
    assign pick  = (req0 & req1) ? ~last : req1;

    // granted master's signals, selected by the registered grant only
    logic                   g_awvalid, g_wvalid, g_arvalid, g_rready;
    logic [pADDR_WIDTH-1:0] g_awaddr, g_araddr;
    logic [pDATA_WIDTH-1:0] g_wdata;
    assign g_awvalid = gnt ? m1_awvalid : m0_awvalid;
    assign g_wvalid  = gnt ? m1_wvalid  : m0_wvalid;
    assign g_arvalid = gnt ? m1_arvalid : m0_arvalid;
    assign g_rready  = gnt ? m1_rready  : m0_rready;
    assign g_awaddr  = gnt ? m1_awaddr  : m0_awaddr;
    assign g_araddr  = gnt ? m1_araddr  : m0_araddr;
    assign g_wdata   = gnt ? m1_wdata   : m0_wdata;

    logic aw_hs, w_hs, ar_hs, r_hs;
    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;
    assign ar_hs = arvalid & arready;
    assign r_hs  = rvalid & rready;

    assign dbg_st   = st;
    assign dbg_last = last;

    // channel routing
    always_comb begin
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        awaddr     = '0;
        wdata      = '0;
        araddr     = '0;
        m0_awready = 1'b0;
        m0_wready  = 1'b0;
        m0_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m0_rdata   = '0;
        m1_awready = 1'b0;
        m1_wready  = 1'b0;
        m1_arready = 1'b0;
        m1_rvalid  = 1'b0;
        m1_rdata   = '0;
        case (st)
            WR: begin
                // done flags mask each channel after its single beat
                awvalid = g_awvalid & ~aw_done;
                wvalid  = g_wvalid & ~w_done;
                awaddr  = g_awaddr;
                wdata   = g_wdata;
                if (gnt) begin
                    m1_awready = awready & ~aw_done;
                    m1_wready  = wready & ~w_done;
                end else begin
                    m0_awready = awready & ~aw_done;
                    m0_wready  = wready & ~w_done;
                end
            end
            RD: begin
                arvalid = g_arvalid & ~ar_done;
                araddr  = g_araddr;
                // R is only accepted once the address has been issued
                rready  = g_rready & ar_done;
                if (gnt) begin
                    m1_arready = arready & ~ar_done;
                    m1_rvalid  = rvalid & ar_done;
                    m1_rdata   = rdata;
                end else begin
                    m0_arready = arready & ~ar_done;
                    m0_rvalid  = rvalid & ar_done;
                    m0_rdata   = rdata;
                end
            end
            default: ;
        endcase
    end

    // next state
    always_comb begin
        st_nxt      = st;
        gnt_nxt     = gnt;
        last_nxt    = last;
        aw_done_nxt = aw_done;
        w_done_nxt  = w_done;
        ar_done_nxt = ar_done;
        case (st)
            IDLE: begin
                if (req0 | req1) begin
                    gnt_nxt = pick;
                    // a write wins over a read from the same master
                    st_nxt  = (pick ? wreq1 : wreq0) ? WR : RD;
                end
            end
            WR: begin
                if ((aw_done | aw_hs) & (w_done | w_hs)) begin
                    st_nxt      = IDLE;
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                    last_nxt    = gnt;
                end else begin
                    aw_done_nxt = aw_done | aw_hs;
                    w_done_nxt  = w_done | w_hs;
                end
            end
            RD: begin
                if (r_hs) begin
                    st_nxt      = IDLE;
                    ar_done_nxt = 1'b0;
                    last_nxt    = gnt;
                end else if (ar_hs) begin
                    ar_done_nxt = 1'b1;
                end
            end
            default: st_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            st      <= IDLE;
            gnt     <= 1'b0;
            last    <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            ar_done <= 1'b0;
        end else begin
            st      <= st_nxt;
            gnt     <= gnt_nxt;
            last    <= last_nxt;
            aw_done <= aw_done_nxt;
            w_done  <= w_done_nxt;
            ar_done <= ar_done_nxt;
        end
    end

endmodule

// File: tb/tb_axil_arbiter2.sv
module tb_axil_arbiter2;
    localparam int AW = 12;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          m0_awvalid, m0_awready, m0_wvalid, m0_wready;
    logic          m0_arvalid, m0_arready, m0_rvalid, m0_rready;
    logic [AW-1:0] m0_awaddr, m0_araddr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_awvalid, m1_awready, m1_wvalid, m1_wready;
    logic          m1_arvalid, m1_arready, m1_rvalid, m1_rready;
    logic [AW-1:0] m1_awaddr, m1_araddr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic          awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
    logic [AW-1:0] awaddr, araddr;
    logic [DW-1:0] wdata, rdata;
    logic          gnt;
    logic [1:0]    dbg_st;
    logic          dbg_last;

    int checks = 0;
    int failures = 0;

    // scoreboard queues: {master, value}
    logic [32:0] exp_aw_q[$];
    logic [32:0] exp_w_q[$];
    logic [32:0] exp_ar_q[$];
    logic [32:0] exp_r_q[$];

    axil_arbiter2 #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m0_awvalid(m0_awvalid), .m0_awready(m0_awready), .m0_awaddr(m0_awaddr),
        .m0_wvalid(m0_wvalid), .m0_wready(m0_wready), .m0_wdata(m0_wdata),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata),
        .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr),
        .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .gnt(gnt), .dbg_st(dbg_st), .dbg_last(dbg_last)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_awvalid = 0; m0_wvalid = 0; m0_arvalid = 0; m0_rready = 0;
        m0_awaddr = '0; m0_wdata = '0; m0_araddr = '0;
        m1_awvalid = 0; m1_wvalid = 0; m1_arvalid = 0; m1_rready = 0;
        m1_awaddr = '0; m1_wdata = '0; m1_araddr = '0;
        awready = 0; wready = 0; arready = 0; rvalid = 0; rdata = '0;
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=extra_beat required=no_beat", name);
    endtask

    // monitor: pops an expectation for every beat the DUT presents
    logic [32:0] e;
    always @(negedge clk) begin
        if (!rst) begin
            if (awvalid && awready) begin
                if (exp_aw_q.size() == 0) unexpected("aw_beat");
                else begin e = exp_aw_q.pop_front(); check("aw_beat", {gnt, 20'b0, awaddr}, e); end
            end
            if (wvalid && wready) begin
                if (exp_w_q.size() == 0) unexpected("w_beat");
                else begin e = exp_w_q.pop_front(); check("w_beat", {gnt, wdata}, e); end
            end
            if (arvalid && arready) begin
                if (exp_ar_q.size() == 0) unexpected("ar_beat");
                else begin e = exp_ar_q.pop_front(); check("ar_beat", {gnt, 20'b0, araddr}, e); end
            end
            if (m0_rvalid && m0_rready) begin
                if (exp_r_q.size() == 0) unexpected("r0_beat");
                else begin e = exp_r_q.pop_front(); check("r0_beat", {1'b0, m0_rdata}, e); end
            end
            if (m1_rvalid && m1_rready) begin
                if (exp_r_q.size() == 0) unexpected("r1_beat");
                else begin e = exp_r_q.pop_front(); check("r1_beat", {1'b1, m1_rdata}, e); end
            end
        end
    end

    initial begin
        clear_inputs();
        rst = 1;
        next_cycle();
        next_cycle();
        rst = 0;
        @(negedge clk);
        check("rst_st", dbg_st, 0);
        check("rst_gnt", gnt, 0);
        check("rst_last", dbg_last, 1);
        check("rst_awvalid", awvalid, 0);

        // single write from m0, zero-wait slave
        next_cycle();
        m0_awvalid = 1; m0_awaddr = 12'h010; m0_wvalid = 1; m0_wdata = 32'h40;
        awready = 1; wready = 1;
        exp_aw_q.push_back({1'b0, 32'h10});
        exp_w_q.push_back({1'b0, 32'h40});
        @(negedge clk);
        check("w1_t_st", dbg_st, 0);
        check("w1_t_awvalid", awvalid, 0);
        next_cycle();
        @(negedge clk);
        check("w1_awvalid", awvalid, 1);
        check("w1_wvalid", wvalid, 1);
        check("w1_m0_awready", m0_awready, 1);
        check("w1_m0_wready", m0_wready, 1);
        check("w1_m1_awready", m1_awready, 0);
        check("w1_gnt", gnt, 0);
        next_cycle();
        m0_awvalid = 0; m0_wvalid = 0;
        @(negedge clk);
        check("w1_idle", dbg_st, 0);
        check("w1_awvalid_off", awvalid, 0);

        // split write from m1: AW at t+1, W at t+3 (master keeps awvalid high)
        m1_awvalid = 1; m1_awaddr = 12'h020; m1_wvalid = 1; m1_wdata = 32'h12345678;
        awready = 0; wready = 0;
        exp_aw_q.push_back({1'b1, 32'h20});
        exp_w_q.push_back({1'b1, 32'h12345678});
        next_cycle();
        awready = 1;
        @(negedge clk);
        check("w2_awvalid", awvalid, 1);
        check("w2_m1_awready", m1_awready, 1);
        check("w2_m1_wready", m1_wready, 0);
        check("w2_gnt", gnt, 1);
        next_cycle();
        awready = 0;
        @(negedge clk);
        check("w2_awvalid_dropped", awvalid, 0);
        check("w2_wvalid_held", wvalid, 1);
        check("w2_st_wr", dbg_st, 1);
        next_cycle();
        wready = 1; awready = 1;
        @(negedge clk);
        check("w2_m1_wready", m1_wready, 1);
        check("w2_no_second_aw", m1_awready, 0);
        check("w2_awvalid_masked", awvalid, 0);
        next_cycle();
        m1_awvalid = 0; m1_wvalid = 0; awready = 0; wready = 0;
        @(negedge clk);
        check("w2_idle", dbg_st, 0);
        check("w2_last", dbg_last, 1);

        // read from m0, rvalid two cycles after AR
        m0_arvalid = 1; m0_araddr = 12'h000; m0_rready = 1; arready = 1;
        exp_ar_q.push_back({1'b0, 32'h0});
        next_cycle();
        @(negedge clk);
        check("r1_arvalid", arvalid, 1);
        check("r1_m0_arready", m0_arready, 1);
        check("r1_gnt", gnt, 0);
        check("r1_rready_pre_ar", rready, 0);
        next_cycle();
        m0_arvalid = 0; arready = 0;
        @(negedge clk);
        check("r1_st_rd", dbg_st, 2);
        check("r1_arvalid_off", arvalid, 0);
        check("r1_m0_rvalid_wait", m0_rvalid, 0);
        next_cycle();
        rvalid = 1; rdata = 32'h4;
        exp_r_q.push_back({1'b0, 32'h4});
        @(negedge clk);
        check("r1_m0_rvalid", m0_rvalid, 1);
        check("r1_m0_rdata", m0_rdata, 32'h4);
        check("r1_m1_rvalid", m1_rvalid, 0);
        next_cycle();
        rvalid = 0; rdata = '0;
        @(negedge clk);
        check("r1_idle", dbg_st, 0);
        check("r1_m0_rvalid_once", m0_rvalid, 0);
        check("r1_last", dbg_last, 0);

        // reset pulsed in RD after AR, before rvalid
        m0_arvalid = 1; m0_araddr = 12'h00c; arready = 1;
        exp_ar_q.push_back({1'b0, 32'hc});
        next_cycle();
        @(negedge clk);
        check("rst_rd_arvalid", arvalid, 1);
        next_cycle();
        m0_arvalid = 0; arready = 0; rst = 1;
        @(negedge clk);
        check("rst_rd_st", dbg_st, 2);
        next_cycle();
        rst = 0; rvalid = 1; rdata = 32'hdead;
        @(negedge clk);
        check("rst_rd_idle", dbg_st, 0);
        check("rst_rd_rready", rready, 0);
        check("rst_rd_m0_rvalid", m0_rvalid, 0);
        check("rst_rd_readies", {m0_awready, m0_wready, m0_arready, m1_awready, m1_wready, m1_arready}, 0);
        check("rst_rd_last", dbg_last, 1);
        check("rst_rd_arvalid", arvalid, 0);
        next_cycle();
        rvalid = 0; rdata = '0; m0_rready = 0;

        // both masters writing continuously from reset: m0, m1, m0, m1
        m0_awvalid = 1; m0_awaddr = 12'h100; m0_wvalid = 1; m0_wdata = 32'ha0;
        m1_awvalid = 1; m1_awaddr = 12'h104; m1_wvalid = 1; m1_wdata = 32'hb1;
        awready = 1; wready = 1;
        for (int k = 0; k < 4; k++) begin
            exp_aw_q.push_back((k % 2 == 0) ? {1'b0, 32'h100} : {1'b1, 32'h104});
            exp_w_q.push_back((k % 2 == 0) ? {1'b0, 32'ha0} : {1'b1, 32'hb1});
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c % 2 == 0) begin
                check($sformatf("rr_idle_c%0d", c), dbg_st, 0);
            end else begin
                check($sformatf("rr_wr_c%0d", c), dbg_st, 1);
                check($sformatf("rr_gnt_c%0d", c), gnt, (c >> 1) & 1);
            end
            next_cycle();
        end
        m0_awvalid = 0; m0_wvalid = 0; m1_awvalid = 0; m1_wvalid = 0;
        @(negedge clk);
        check("rr_done_idle", dbg_st, 0);
        check("rr_all_aw", exp_aw_q.size(), 0);
        check("rr_all_w", exp_w_q.size(), 0);

        // m1 write and read together: write first, one IDLE, then read
        next_cycle();
        m1_awvalid = 1; m1_awaddr = 12'h000; m1_wvalid = 1; m1_wdata = 32'h77;
        m1_arvalid = 1; m1_araddr = 12'h008; m1_rready = 1;
        awready = 1; wready = 1; arready = 1;
        exp_aw_q.push_back({1'b1, 32'h0});
        exp_w_q.push_back({1'b1, 32'h77});
        exp_ar_q.push_back({1'b1, 32'h8});
        @(negedge clk);
        check("wr_rd_t_idle", dbg_st, 0);
        next_cycle();
        @(negedge clk);
        check("wr_rd_wr_first", dbg_st, 1);
        check("wr_rd_gnt", gnt, 1);
        check("wr_rd_no_ar", arvalid, 0);
        next_cycle();
        m1_awvalid = 0; m1_wvalid = 0;
        @(negedge clk);
        check("wr_rd_gap", dbg_st, 0);
        next_cycle();
        @(negedge clk);
        check("wr_rd_rd", dbg_st, 2);
        check("wr_rd_arvalid", arvalid, 1);
        check("wr_rd_m1_arready", m1_arready, 1);
        next_cycle();
        m1_arvalid = 0; rvalid = 1; rdata = 32'h55;
        exp_r_q.push_back({1'b1, 32'h55});
        @(negedge clk);
        check("wr_rd_m1_rvalid", m1_rvalid, 1);
        check("wr_rd_m1_rdata", m1_rdata, 32'h55);
        check("wr_rd_m0_rvalid", m0_rvalid, 0);
        next_cycle();
        rvalid = 0; rdata = '0;
        @(negedge clk);
        check("wr_rd_idle", dbg_st, 0);

        // final report
        next_cycle();
        check("end_aw_q", exp_aw_q.size(), 0);
        check("end_w_q", exp_w_q.size(), 0);
        check("end_ar_q", exp_ar_q.size(), 0);
        check("end_r_q", exp_r_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
